seg_display_arbiter: RTL and testbench

Shares the board's 5-digit seven-segment display between several 16-bit value sources, such as the PC, ALU result and a debug register. It grants the display to one requester at a time by round-robin and converts the granted value to BCD with a sequential shift-add-3 engine, one bit per clock. It then holds the value for a minimum dwell time while continuously time-multiplexing the five digits onto the shared anode/cathode pins. It sits between the processor's status sources and the board display pins.

---
 rtl/seg_display_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
// Grants a shared 5-digit seven-segment display to one of NREQ 16-bit value
// sources by round-robin, converts the captured value to BCD with a
// one-bit-per-clock shift-add-3 engine, holds it for a minimum dwell time and
// continuously scans the five digits onto the shared anode/cathode pins.
module seg_display_arbiter #(
  parameter int NREQ        = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [16*NREQ-1:0]   data_i,
  output logic [NREQ-1:0]      ack_o,
  output logic                 busy_o,
  output logic [2:0]           src_o,
  output logic [7:0]           anodes_o,
  output logic [7:0]           cathodes_o
);

  localparam int DATA_W = 16;
  localparam int NDIG   = 5;
  localparam int BCD_W  = 4 * NDIG;
  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PS_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    DWELL = 2'd2
  } state_t;

  // Add-3 correction applied to every BCD nibble above 4 before each shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] > 4'd4) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; non-decimal nibbles go dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  state_t             state_q, state_d;

  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         iter_q, iter_d;
  logic [2:0]         last_grant_q, last_grant_d;
  logic [BCD_W-1:0]   disp_bcd_q, disp_bcd_d;
  logic [2:0]         src_q, src_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]    ack_q, ack_d;

  logic [PS_W-1:0]    ps_q, ps_d;
  logic [2:0]         digit_q, digit_d;

  logic               win_found;
  logic [2:0]         win_idx;
  logic [NREQ-1:0]    win_onehot;
  logic [DATA_W-1:0]  win_data;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_step;

  logic [2:0]         msd;
  logic [3:0]         cur_nib;

  // Round-robin pick: first active request after last_grant, with wrap.
  always_comb begin
    int cand;
    cand       = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_data   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_grant_q) + i) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && (j == cand) && req_i[j]) begin
          win_found     = 1'b1;
          win_idx       = 3'(j);
          win_onehot[j] = 1'b1;
          win_data      = data_i[DATA_W*j +: DATA_W];
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: capture, 16 conversion steps, then dwell countdown.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = CONV;
      CONV:    if (iter_q == 4'd15) state_d = DWELL;
      DWELL:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the display is owned from capture until the dwell expires.
  always_comb begin
    busy_o = (state_q != IDLE);
  end

  // Datapath next values: capture, shift-add-3 step, result load and dwell.
  always_comb begin
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    last_grant_d = last_grant_q;
    disp_bcd_d   = disp_bcd_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    ack_d        = '0;
    bcd_adj      = bcd_adjust(bcd_q);
    bcd_step     = (bcd_adj << 1) | BCD_W'(sh_q[DATA_W-1]);
    case (state_q)
      IDLE: begin
        if (win_found) begin
          sh_d         = win_data;
          bcd_d        = '0;
          iter_d       = '0;
          ack_d        = win_onehot;
          last_grant_d = win_idx;
        end
      end
      CONV: begin
        bcd_d  = bcd_step;
        sh_d   = sh_q << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          disp_bcd_d = bcd_step;
          src_d      = last_grant_q;
          cnt_d      = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears the display back to a single "0".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q         <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      last_grant_q <= 3'(NREQ - 1);
      disp_bcd_q   <= '0;
      src_q        <= '0;
      cnt_q        <= '0;
      ack_q        <= '0;
    end else begin
      sh_q         <= sh_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      last_grant_q <= last_grant_d;
      disp_bcd_q   <= disp_bcd_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
    end
  end

  assign ack_o = ack_q;
  assign src_o = src_q;

  // Free-running scan prescaler; the digit pointer steps 0..4 on each wrap.
  always_comb begin
    ps_d    = ps_q + PS_W'(1);
    digit_d = digit_q;
    if (ps_q == PS_W'(SCAN_DIV - 1)) begin
      ps_d    = '0;
      digit_d = (digit_q == 3'(NDIG - 1)) ? 3'd0 : digit_q + 3'd1;
    end
  end

  // Scan registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q    <= '0;
      digit_q <= '0;
    end else begin
      ps_q    <= ps_d;
      digit_q <= digit_d;
    end
  end

  // Pin decode from registered state only, with leading-zero blanking.
  always_comb begin
    msd     = '0;
    cur_nib = '0;
    for (int k = 1; k < NDIG; k++) begin
      if (disp_bcd_q[4*k +: 4] != 4'd0) begin
        msd = 3'(k);
      end
    end
    for (int k = 0; k < NDIG; k++) begin
      if (digit_q == 3'(k)) begin
        cur_nib = disp_bcd_q[4*k +: 4];
      end
    end
    anodes_o   = ~(8'b1 << digit_q);
    cathodes_o = (digit_q > msd) ? 8'hFF : seg_decode(cur_nib);
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus randomized requests,
// all outputs compared every cycle against a timestamp-based reference model.
module tb_seg_display_arbiter;

  localparam int NREQ     = 4;
  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 8;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [NREQ-1:0]     req_i;
  logic [16*NREQ-1:0]  data_i;
  logic [NREQ-1:0]     ack_o;
  logic                busy_o;
  logic [2:0]          src_o;
  logic [7:0]          anodes_o;
  logic [7:0]          cathodes_o;

  seg_display_arbiter #(
    .NREQ        (NREQ),
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .busy_o     (busy_o),
    .src_o      (src_o),
    .anodes_o   (anodes_o),
    .cathodes_o (cathodes_o)
  );

  always #5 clk_i = ~clk_i;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Reference model state: edges since reset release plus capture timestamps.
  int              edge_n;
  int              m_last;
  int              m_next_ok;
  int              m_cap;
  int              m_val;
  int              m_win;
  int              m_disp;
  int              m_src;
  logic [NREQ-1:0] exp_ack;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: observed %0h expected %0h at %0t", phase, tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cath(input int v, input int d);
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (d > 0 && v < p) return 8'hFF;
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic model_reset();
    edge_n    = 0;
    m_last    = NREQ - 1;
    m_next_ok = 1;
    m_cap     = -1000;
    m_val     = 0;
    m_win     = 0;
    m_disp    = 0;
    m_src     = 0;
    exp_ack   = '0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    edge_n++;
    exp_ack = '0;
    if (edge_n >= m_next_ok && req_i != '0) begin
      for (int i = 1; i <= NREQ; i++) begin
        int k;
        k = (m_last + i) % NREQ;
        if (req_i[k]) begin
          m_cap      = edge_n;
          m_win      = k;
          m_val      = int'(data_i[16*k +: 16]);
          m_last     = k;
          m_next_ok  = edge_n + 17 + HOLD;
          exp_ack[k] = 1'b1;
          break;
        end
      end
    end
    if (edge_n == m_cap + 16) begin
      m_disp = m_val;
      m_src  = m_win;
    end
  endtask

  task automatic check_outputs();
    int d;
    bit busy_e;
    d      = (edge_n / SCAN_DIV) % 5;
    busy_e = (edge_n >= m_cap) && (edge_n < m_cap + 16 + HOLD);
    chk_eq("ack", ack_o, exp_ack);
    chk_eq("busy", busy_o, busy_e);
    chk_eq("src", src_o, m_src);
    chk_eq("anodes", anodes_o, 8'hFF ^ (8'h01 << d));
    chk_eq("cathodes", cathodes_o, exp_cath(m_disp, d));
  endtask

  task automatic step();
    @(posedge clk_i);
    if (rst_ni) model_edge();
    @(negedge clk_i);
    check_outputs();
  endtask

  task automatic set_req(input int k, input logic [15:0] v);
    data_i[16*k +: 16] = v;
    req_i[k] = 1'b1;
  endtask

  task automatic pulse_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic drop_acked();
    for (int k = 0; k < NREQ; k++) begin
      if (exp_ack[k]) req_i[k] = 1'b0;
    end
  endtask

  initial begin
    int busy_cnt;
    int n_gr;
    int ack2;
    rst_ni = 1'b0;
    req_i  = '0;
    data_i = '0;
    model_reset();

    phase = "reset";
    @(negedge clk_i);
    check_outputs();
    @(negedge clk_i);
    check_outputs();
    rst_ni = 1'b1;

    phase = "scan";
    repeat (25) step();

    phase = "ffff";
    set_req(0, 16'hFFFF);
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      drop_acked();
      if (busy_o) busy_cnt++;
    end
    chk_eq("busy_len", busy_cnt, 24);

    phase = "d305";
    set_req(0, 16'd305);
    for (int c = 0; c < 30; c++) begin
      step();
      drop_acked();
    end

    phase = "rr";
    pulse_reset();
    set_req(0, 16'd1);
    set_req(1, 16'd2);
    set_req(2, 16'd3);
    set_req(3, 16'd4);
    n_gr = 0;
    for (int c = 0; c < 110; c++) begin
      step();
      if (ack_o != '0) begin
        if (n_gr < 5) chk_eq("order", ack_o, 32'(1) << (n_gr % 4));
        n_gr++;
      end
    end
    chk_eq("grants", n_gr, 5);
    req_i = '0;
    repeat (30) step();

    phase = "dwell";
    set_req(0, 16'd42);
    step();
    req_i[0] = 1'b0;
    repeat (20) step();
    set_req(2, 16'd999);
    ack2 = 0;
    repeat (4) begin
      step();
      if (ack_o[2]) ack2++;
    end
    req_i[2] = 1'b0;
    repeat (15) begin
      step();
      if (ack_o[2]) ack2++;
    end
    chk_eq("no_ack2", ack2, 0);

    phase = "abort";
    set_req(0, 16'd9999);
    step();
    req_i[0] = 1'b0;
    repeat (8) step();
    pulse_reset();
    repeat (3) step();

    phase = "seven";
    set_req(0, 16'd7);
    for (int c = 0; c < 30; c++) begin
      step();
      drop_acked();
    end

    phase = "random";
    for (int c = 0; c < 1500; c++) begin
      step();
      if (c == 700) pulse_reset();
      for (int k = 0; k < NREQ; k++) begin
        if (exp_ack[k]) begin
          req_i[k] = 1'b0;
        end else if (!req_i[k] && $urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0:       set_req(k, 16'($urandom_range(0, 65535)));
            1:       set_req(k, 16'd0);
            default: set_req(k, 16'($urandom_range(0, 999)));
          endcase
        end else if (req_i[k] && $urandom_range(0, 63) == 0) begin
          req_i[k] = 1'b0;
        end else if (req_i[k] && $urandom_range(0, 15) == 0) begin
          data_i[16*k +: 16] = 16'($urandom_range(0, 65535));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
